seq_divider: RTL and testbench

- Parameterised sequential restoring divider; the inverse operation of the team's shift-add sequential multiplier.
- Produces one quotient bit per clock and uses a start/done handshake.
- Used in the DDS datapath to normalise and rescale values, for example frequency word = target / step.
- Sized for small area on the TinyTapeout tile: a single subtractor, with no array logic.

---
 rtl/dds_pkg.sv | 22 ++
 rtl/seq_divider_div_step.sv | 33 +++
 rtl/seq_divider.sv | 113 +++++++++++
 tb/tb_seq_divider.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared definitions for the DDS datapath blocks.
//   div_state_t : sequential divider FSM encoding (IDLE / RUN / DONE).
//   DIV_M       : default divider operand width.
//   div_cnt_w() : step-counter width for a given operand width. It must be
//                 able to hold the value m itself, hence $clog2(m+1).
package dds_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int DIV_M = 12;

  function automatic int div_cnt_w(input int m);
    return $clog2(m + 1);
  endfunction

  localparam int DIV_CNT_W = div_cnt_w(DIV_M);

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
//   i_r    [m-1:0] : partial remainder before the step
//   i_bit          : next dividend bit, shifted in at the LSB
//   i_dvs  [m-1:0] : divisor
//   o_r    [m-1:0] : partial remainder after the step
//   o_qbit         : quotient bit produced by this step
module div_step
  import dds_pkg::*;
#(
  parameter int m = 12
) (
  input  logic [m-1:0] i_r,
  input  logic         i_bit,
  input  logic [m-1:0] i_dvs,
  output logic [m-1:0] o_r,
  output logic         o_qbit
);

  logic [m:0] w_t;
  logic [m:0] w_diff;
  logic       w_ge;

  // The m+1 bit trial value exists only for the compare. Either branch fits
  // back into m bits: the difference is below the divisor, and the
  // unrestored value is below the divisor too.
  assign w_t    = {i_r, i_bit};
  assign w_ge   = (w_t >= {1'b0, i_dvs});
  assign w_diff = w_t - {1'b0, i_dvs};

  assign o_r    = w_ge ? w_diff[m-1:0] : w_t[m-1:0];
  assign o_qbit = w_ge;

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential restoring divider, one quotient bit per clock.
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : request; accepted only in IDLE or DONE
//   dividend    : [m-1:0] numerator, latched on accept
//   divisor     : [m-1:0] denominator, latched on accept
//   quotient    : [m-1:0] registered result, updated on entry to DONE
//   remainder   : [m-1:0] registered result, updated on entry to DONE
//   busy        : high while iterating (m cycles)
//   done        : one-cycle pulse when results become valid
//   div_by_zero : latched divisor was zero; valid with done
// A zero divisor takes the ordinary path: every step subtracts zero, so the
// quotient saturates to all ones and the remainder reassembles the dividend.
module seq_divider
  import dds_pkg::*;
#(
  parameter int m = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [m-1:0] dividend,
  input  logic [m-1:0] divisor,
  output logic [m-1:0] quotient,
  output logic [m-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);

  localparam int CNT_W = div_cnt_w(m);

  div_state_t r_state, w_state_nxt;

  logic [m-1:0]     r_rem;
  logic [m-1:0]     r_q;
  logic [m-1:0]     r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic [m-1:0]     r_quot;
  logic [m-1:0]     r_remo;
  logic             r_dbz;

  logic [m-1:0] w_r;
  logic         w_qbit;
  logic         w_accept;
  logic         w_last;

  div_step #(.m(m)) u_step (
    .i_r    (r_rem),
    .i_bit  (r_q[m-1]),
    .i_dvs  (r_dvs),
    .o_r    (w_r),
    .o_qbit (w_qbit)
  );

  assign w_accept = start && (r_state == DIV_IDLE || r_state == DIV_DONE);
  assign w_last   = (r_state == DIV_RUN) && (r_cnt == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= DIV_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      DIV_IDLE: if (w_accept) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (w_last)   w_state_nxt = DIV_DONE;
      DIV_DONE: w_state_nxt = w_accept ? DIV_RUN : DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  // Datapath. The dividend is shifted out of r_q MSB-first while quotient
  // bits are shifted in at the LSB, so after m steps r_q holds the quotient.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rem <= '0;
        r_q   <= dividend;
        r_dvs <= divisor;
        r_cnt <= CNT_W'(m);
      end else if (r_state == DIV_RUN) begin
        r_rem <= w_r;
        r_q   <= {r_q[m-2:0], w_qbit};
        r_cnt <= r_cnt - CNT_W'(1);
      end
      // Results are published only on the edge that enters DONE and then
      // hold through IDLE and the next RUN.
      if (w_last) begin
        r_quot <= {r_q[m-2:0], w_qbit};
        r_remo <= w_r;
        r_dbz  <= (r_dvs == '0);
      end
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;
  assign busy        = (r_state == DIV_RUN);
  assign done        = (r_state == DIV_DONE);

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  localparam int M = 12;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [M-1:0] dividend = '0;
  logic [M-1:0] divisor = '0;
  logic [M-1:0] quotient, remainder;
  logic         busy, done, div_by_zero;

  seq_divider #(.m(M)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Last published result, used to check that outputs hold during RUN.
  logic [M-1:0] last_q = '0;
  logic [M-1:0] last_r = '0;
  logic         last_z = 1'b0;

  typedef struct {
    logic [M-1:0] dd;
    logic [M-1:0] dv;
    logic [M-1:0] eq;
    logic [M-1:0] er;
    logic         ez;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One full operation from IDLE: accept at edge T, busy for T+1..T+M,
  // done in T+M+1 only. Operands are scrambled right after acceptance.
  task automatic run_div(input string nm, input logic [M-1:0] dd, input logic [M-1:0] dv,
                         input logic [M-1:0] eq, input logic [M-1:0] er, input logic ez);
    int bad_busy;
    int bad_hold;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    @(negedge clk);                       // cycle T+1
    start = 1'b0; dividend = ~dd; divisor = dd ^ dv;
    bad_busy = 0; bad_hold = 0;
    for (int i = 1; i <= M; i++) begin
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) bad_hold++;
      @(negedge clk);
    end                                   // cycle T+M+1
    chk({nm, " busy_run"}, bad_busy, 0);
    chk({nm, " hold_run"}, bad_hold, 0);
    chk({nm, " busy_done"}, {busy, done}, 2'b01);
    chk({nm, " quotient"}, quotient, eq);
    chk({nm, " remainder"}, remainder, er);
    chk({nm, " div_by_zero"}, div_by_zero, ez);
    last_q = eq; last_r = er; last_z = ez;
    @(negedge clk);
    chk({nm, " done_pulse"}, {busy, done}, 2'b00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int nbusy;
    int bad;
    logic exp_done;

    vecs[0] = '{12'd100,  12'd7,    12'd14,   12'd2,   1'b0};
    vecs[1] = '{12'd4095, 12'd1,    12'd4095, 12'd0,   1'b0};
    vecs[2] = '{12'd3,    12'd10,   12'd0,    12'd3,   1'b0};
    vecs[3] = '{12'd4095, 12'd4095, 12'd1,    12'd0,   1'b0};
    vecs[4] = '{12'd5,    12'd0,    12'd4095, 12'd5,   1'b1};
    vecs[5] = '{12'd9,    12'd3,    12'd3,    12'd0,   1'b0};
    vecs[6] = '{12'd0,    12'd5,    12'd0,    12'd0,   1'b0};
    vecs[7] = '{12'd2048, 12'd64,   12'd32,   12'd0,   1'b0};
    vecs[8] = '{12'd1234, 12'd56,   12'd22,   12'd2,   1'b0};
    vecs[9] = '{12'd4094, 12'd2,    12'd2047, 12'd0,   1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset busy_done_dbz", {busy, done, div_by_zero}, 3'b000);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++)
      run_div($sformatf("vec%0d", i), vecs[i].dd, vecs[i].dv, vecs[i].eq, vecs[i].er, vecs[i].ez);

    // start pulsed during RUN is ignored
    @(negedge clk);
    dividend = 12'd200; divisor = 12'd9; start = 1'b1;
    @(negedge clk);                       // cycle T+1
    dividend = 12'd1; divisor = 12'd1;
    ndone = 0;
    for (int i = 1; i <= M; i++) begin
      if (done === 1'b1) ndone++;
      start = (i % 2 == 1);
      @(negedge clk);
    end                                   // cycle T+M+1
    start = 1'b0;
    chk("ign done_at_T13", done, 1);
    chk("ign quotient", quotient, 22);
    chk("ign remainder", remainder, 2);
    chk("ign early_done", ndone, 0);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    chk("ign extra_done", ndone, 0);
    chk("ign extra_busy", nbusy, 0);
    last_q = 12'd22; last_r = 12'd2; last_z = 1'b0;

    // start held high: back-to-back every M+1 cycles
    @(negedge clk);
    dividend = 12'd50; divisor = 12'd5; start = 1'b1;
    @(negedge clk);                       // cycle T+1
    bad = 0;
    for (int c = 1; c <= 3 * (M + 1); c++) begin
      exp_done = (c % (M + 1) == 0);
      if (done !== exp_done) bad++;
      if (exp_done) begin
        chk($sformatf("b2b quotient c%0d", c), quotient, 10);
        chk($sformatf("b2b remainder c%0d", c), remainder, 0);
      end
      if (c == 3 * (M + 1)) start = 1'b0;
      @(negedge clk);
    end
    chk("b2b done_pattern", bad, 0);
    chk("b2b idle_after", {busy, done}, 2'b00);
    last_q = 12'd10; last_r = 12'd0; last_z = 1'b0;

    // Reset mid-division at edge T+5
    @(negedge clk);
    dividend = 12'd1000; divisor = 12'd3; start = 1'b1;
    @(negedge clk);                       // cycle T+1
    start = 1'b0;
    repeat (3) @(negedge clk);            // cycle T+4
    rst_n = 1'b0;
    @(negedge clk);                       // cycle T+5, after reset edge
    rst_n = 1'b1;
    chk("rst quotient", quotient, 0);
    chk("rst remainder", remainder, 0);
    chk("rst busy_done_dbz", {busy, done, div_by_zero}, 3'b000);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < M + 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
      if (busy === 1'b1) nbusy++;
    end
    chk("rst no_done", ndone, 0);
    chk("rst no_busy", nbusy, 0);
    last_q = '0; last_r = '0; last_z = 1'b0;
    run_div("post_rst", 12'd1000, 12'd3, 12'd333, 12'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
